// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and the
// sequence-detector benches that consume its stream.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle of seq_pattern_tx: master drives the request side,
// slave (the transmitter) drives the serial stream and status.
interface seq_pattern_tx_if
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_n, abort,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_n, abort,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping; zero flag
// reflects the current count.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// repeated max(repeat_n,1) times. Define SEQ_PATTERN_TX_GAP_EN for idle gaps.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_LEN = 2
) (
  input  logic            clk,
  input  logic            reset,
  seq_pattern_tx_if.slave bus
);

  localparam int                IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(PAT_W - 1);

  if (PAT_W < 2 || GAP_LEN < 1) begin : g_bad_params
    $error("seq_pattern_tx: PAT_W must be >= 2 and GAP_LEN >= 1");
  end

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] bit_idx, bit_idx_nx;
  logic             start_acc;
  logic             out_q, valid_q, busy_q, done_q;
  logic             out_nx, valid_nx, busy_nx, done_nx;

  logic             reps_dec, reps_zero, last_rep;
  logic [CNT_W-1:0] reps_init, reps_cnt;

  assign reps_init = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
  assign last_rep  = reps_zero || (reps_cnt == CNT_W'(1));

  seq_down_counter #(.W(CNT_W)) u_reps (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (reps_init),
    .dec      (reps_dec),
    .count    (reps_cnt),
    .zero     (reps_zero)
  );

`ifdef SEQ_PATTERN_TX_GAP_EN
  localparam int GAP_W = $clog2(GAP_LEN + 1);

  logic             gap_load, gap_dec, gap_zero, gap_end;
  logic [GAP_W-1:0] gap_cnt;

  // Exit on the cycle the count reads 1, giving exactly GAP_LEN GAP cycles.
  assign gap_end = gap_zero || (gap_cnt == GAP_W'(1));

  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_LEN)),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );
`endif

  always_comb begin
    state_nx   = state;
    bit_idx_nx = bit_idx;
    start_acc  = 1'b0;
    reps_dec   = 1'b0;
    out_nx     = 1'b0;
    valid_nx   = 1'b0;
    busy_nx    = (state != IDLE);
    done_nx    = 1'b0;
`ifdef SEQ_PATTERN_TX_GAP_EN
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          start_acc  = 1'b1;
          bit_idx_nx = IDX_TOP;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        out_nx   = pat_q[bit_idx];
        valid_nx = 1'b1;
        if (bit_idx != '0) begin
          bit_idx_nx = bit_idx - IDX_W'(1);
        end else if (last_rep) begin
          state_nx = DONE;
        end else begin
          reps_dec   = 1'b1;
          bit_idx_nx = IDX_TOP;
`ifdef SEQ_PATTERN_TX_GAP_EN
          gap_load   = 1'b1;
          state_nx   = GAP;
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_GAP_EN
      GAP: begin
        if (gap_end) begin
          bit_idx_nx = IDX_TOP;
          state_nx   = SHIFT;
        end else begin
          gap_dec = 1'b1;
        end
      end
`endif
      DONE: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Abort squashes this cycle's outputs as well as the next state.
    if (bus.abort && (state != IDLE)) begin
      state_nx = IDLE;
      reps_dec = 1'b0;
      out_nx   = 1'b0;
      valid_nx = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
`ifdef SEQ_PATTERN_TX_GAP_EN
      gap_load = 1'b0;
      gap_dec  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      pat_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_idx <= bit_idx_nx;
      if (start_acc) begin
        pat_q <= bus.pattern;
      end
      out_q   <= out_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
